// File: rtl/vtg_pkg.sv
// Shared definitions for the raster timing generator and its per-axis counters.
// Provides the four-segment state encoding and a helper that sums segment lengths.
// Imported by vtg_axis_counter and video_timing_gen.
package vtg_pkg;

    // Segment order along either axis is fixed: ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } segState_t;

    // Total positions per axis (pixels per line, or lines per frame).
    function automatic int vtgTotal(input int activeLen, input int fpLen,
                                    input int syncLen, input int bpLen);
        return activeLen + fpLen + syncLen + bpLen;
    endfunction

endpackage

// File: rtl/vtg_axis_counter.sv
// Purpose: one raster axis: position counter plus ACTIVE/FP/SYNC/BP segment FSM.
// Latency: count/state are the values the registers hold after the coming clock edge.
// Backpressure: none; 'advance' low freezes every register.
//
// Ports:
//   clock, reset_n : pixel clock, asynchronous active-low reset
//   advance        : step one position on this edge
//   count, state   : post-edge position and segment (equal the registers when advance is low)
//   wrap           : current position is the last one; the next advance returns to 0
module vtg_axis_counter
    import vtg_pkg::*;
#(
    parameter int BUS_WIDTH  = 12,
    parameter int ACTIVE_LEN = 1920,
    parameter int FP_LEN     = 88,
    parameter int SYNC_LEN   = 44,
    parameter int BP_LEN     = 148
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 advance,
    output logic [BUS_WIDTH-1:0] count,
    output segState_t            state,
    output logic                 wrap
);

    localparam int TOTAL = vtgTotal(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);

    if (ACTIVE_LEN < 1 || FP_LEN < 1 || SYNC_LEN < 1 || BP_LEN < 1) begin : gBadSegment
        $error("vtg_axis_counter: every timing segment must be at least 1");
    end
    if (TOTAL - 1 >= (1 << BUS_WIDTH)) begin : gBadWidth
        $error("vtg_axis_counter: total-1 does not fit in BUS_WIDTH bits");
    end

    localparam logic [BUS_WIDTH-1:0] LAST     = BUS_WIDTH'(TOTAL - 1);
    localparam logic [BUS_WIDTH-1:0] RLD_ACT  = BUS_WIDTH'(ACTIVE_LEN - 1);
    localparam logic [BUS_WIDTH-1:0] RLD_FP   = BUS_WIDTH'(FP_LEN - 1);
    localparam logic [BUS_WIDTH-1:0] RLD_SYNC = BUS_WIDTH'(SYNC_LEN - 1);
    localparam logic [BUS_WIDTH-1:0] RLD_BP   = BUS_WIDTH'(BP_LEN - 1);

    logic [BUS_WIDTH-1:0] countQ, countN;
    logic [BUS_WIDTH-1:0] segQ, segN;       // positions left in the current segment, minus one
    segState_t            stateQ, stateN;

    assign wrap = (countQ == LAST);

    always_comb begin
        countN = countQ;
        stateN = stateQ;
        segN   = segQ;
        if (advance) begin
            countN = wrap ? '0 : countQ + BUS_WIDTH'(1);
            if (segQ == '0) begin
                // Segment exhausted: move on and reload with the new segment's length.
                unique case (stateQ)
                    ACTIVE:  begin stateN = FP;     segN = RLD_FP;   end
                    FP:      begin stateN = SYNC;   segN = RLD_SYNC; end
                    SYNC:    begin stateN = BP;     segN = RLD_BP;   end
                    default: begin stateN = ACTIVE; segN = RLD_ACT;  end
                endcase
            end else begin
                segN = segQ - BUS_WIDTH'(1);
            end
        end
    end

    // Reset parks the axis on the final BP position so the first advance lands on 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            countQ <= LAST;
            stateQ <= BP;
            segQ   <= '0;
        end else begin
            countQ <= countN;
            stateQ <= stateN;
            segQ   <= segN;
        end
    end

    assign count = countN;
    assign state = stateN;

endmodule

// File: rtl/video_timing_gen.sv
// Purpose: HDMI/DVI raster timing: hsync, vsync, DE, pixel coordinates, line/frame strobes.
// Latency: all outputs registered from post-update counters; xPos/DE/syncs agree each cycle.
// Backpressure: enable low holds all state and outputs; strobes read 0 while held.
//
// Ports:
//   clock, reset_n          : pixel clock, asynchronous active-low reset
//   enable                  : advance one pixel per clock when high
//   hSyncPulse, vSyncPulse  : syncs at HS_POL / VS_POL while in the SYNC segment
//   DE                      : high in the active region only
//   xPos, yPos              : active coordinates, 0 outside the active region
//   lineStart, frameStart   : one-cycle strobes at hCount==0 / (hCount==0 && vCount==0)
//   frameCount              : frames since reset, wrapping (only with VTG_FRAME_COUNT_EN)
// Build option: define VTG_FRAME_COUNT_EN to add the frameCount output.
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int BUS_WIDTH = 12,
    parameter int H_ACTIVE  = 1920,
    parameter int H_FP      = 88,
    parameter int H_SYNC    = 44,
    parameter int H_BP      = 148,
    parameter int V_ACTIVE  = 1080,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 5,
    parameter int V_BP      = 36,
    parameter bit HS_POL    = 1'b1,
    parameter bit VS_POL    = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enable,
    output logic                 hSyncPulse,
    output logic                 vSyncPulse,
    output logic                 DE,
    output logic [BUS_WIDTH-1:0] xPos,
    output logic [BUS_WIDTH-1:0] yPos,
    output logic                 lineStart,
    output logic                 frameStart
`ifdef VTG_FRAME_COUNT_EN
    ,
    output logic [15:0]          frameCount
`endif
);

    logic [BUS_WIDTH-1:0] hCount, vCount;
    segState_t            hState, vState;
    logic                 hWrap, vWrap;
    logic                 deNext;

    vtg_axis_counter #(
        .BUS_WIDTH (BUS_WIDTH),
        .ACTIVE_LEN(H_ACTIVE),
        .FP_LEN    (H_FP),
        .SYNC_LEN  (H_SYNC),
        .BP_LEN    (H_BP)
    ) uHAxis (
        .clock  (clock),
        .reset_n(reset_n),
        .advance(enable),
        .count  (hCount),
        .state  (hState),
        .wrap   (hWrap)
    );

    // Lines step only on the pixel edge that ends a line.
    vtg_axis_counter #(
        .BUS_WIDTH (BUS_WIDTH),
        .ACTIVE_LEN(V_ACTIVE),
        .FP_LEN    (V_FP),
        .SYNC_LEN  (V_SYNC),
        .BP_LEN    (V_BP)
    ) uVAxis (
        .clock  (clock),
        .reset_n(reset_n),
        .advance(enable && hWrap),
        .count  (vCount),
        .state  (vState),
        .wrap   (vWrap)
    );

    assign deNext = (hState == ACTIVE) && (vState == ACTIVE);

    // hCount/vCount are post-edge values, so registering them here keeps every
    // output aligned with the counter position it describes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            DE         <= 1'b0;
            xPos       <= '0;
            yPos       <= '0;
            hSyncPulse <= ~HS_POL;
            vSyncPulse <= ~VS_POL;
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end else if (enable) begin
            DE         <= deNext;
            xPos       <= deNext ? hCount : '0;
            yPos       <= deNext ? vCount : '0;
            hSyncPulse <= (hState == SYNC) ? HS_POL : ~HS_POL;
            vSyncPulse <= (vState == SYNC) ? VS_POL : ~VS_POL;
            // Wrapping from the last position means this edge lands on position 0.
            lineStart  <= hWrap;
            frameStart <= hWrap && vWrap;
        end else begin
            lineStart  <= 1'b0;
            frameStart <= 1'b0;
        end
    end

`ifdef VTG_FRAME_COUNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            frameCount <= '0;
        end else if (enable && hWrap && vWrap) begin
            frameCount <= frameCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int BW = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;

    logic          hSyncPulse, vSyncPulse, DE, lineStart, frameStart;
    logic [BW-1:0] xPos, yPos;
    logic          hSyncPulseN, vSyncPulseN, DEN, lineStartN, frameStartN;
    logic [BW-1:0] xPosN, yPosN;
`ifdef VTG_FRAME_COUNT_EN
    logic [15:0]   frameCount, frameCountN;
`endif

    int total = 0;
    int bad   = 0;

    // Bench-side raster position: H 8/2/3/1 (14 px), V 4/1/2/1 (8 lines).
    int  h = 13;
    int  v = 7;
    bit  lastAdv = 1'b0;

    always #5 clock = ~clock;

    video_timing_gen #(
        .BUS_WIDTH(BW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .hSyncPulse(hSyncPulse), .vSyncPulse(vSyncPulse), .DE(DE),
        .xPos(xPos), .yPos(yPos), .lineStart(lineStart), .frameStart(frameStart)
`ifdef VTG_FRAME_COUNT_EN
        , .frameCount(frameCount)
`endif
    );

    video_timing_gen #(
        .BUS_WIDTH(BW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .HS_POL(1'b0), .VS_POL(1'b0)
    ) dutN (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .hSyncPulse(hSyncPulseN), .vSyncPulse(vSyncPulseN), .DE(DEN),
        .xPos(xPosN), .yPos(yPosN), .lineStart(lineStartN), .frameStart(frameStartN)
`ifdef VTG_FRAME_COUNT_EN
        , .frameCount(frameCountN)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs were driven at the previous negedge; sample at this negedge.
    task automatic tick();
        bit adv;
        adv = enable && reset_n;
        @(negedge clock);
        if (adv) begin
            h = (h == 13) ? 0 : h + 1;
            if (h == 0) v = (v == 7) ? 0 : v + 1;
        end
        lastAdv = adv;
    endtask

    task automatic checkAll(input string tag);
        bit expDe, expHs, expVs, expLs, expFs;
        expDe = (h < 8) && (v < 4);
        expHs = (h >= 10) && (h <= 12);
        expVs = (v >= 5) && (v <= 6);
        expLs = lastAdv && (h == 0);
        expFs = lastAdv && (h == 0) && (v == 0);
        chk({tag, ".DE"},    DE,         expDe);
        chk({tag, ".xPos"},  xPos,       expDe ? h : 0);
        chk({tag, ".yPos"},  yPos,       expDe ? v : 0);
        chk({tag, ".hs"},    hSyncPulse, expHs);
        chk({tag, ".vs"},    vSyncPulse, expVs);
        chk({tag, ".ls"},    lineStart,  expLs);
        chk({tag, ".fs"},    frameStart, expFs);
        chk({tag, ".hsN"},   hSyncPulseN, !expHs);
        chk({tag, ".vsN"},   vSyncPulseN, !expVs);
        chk({tag, ".DEN"},   DEN,        expDe);
    endtask

    initial begin
        int deLine0, hsLine0, frames, vsCycles, vsRiseH;
        logic prevVs;

        // ---- reset state ----
        tick();
        tick();
        chk("rst.DE", DE, 0);
        chk("rst.xPos", xPos, 0);
        chk("rst.yPos", yPos, 0);
        chk("rst.hs", hSyncPulse, 0);
        chk("rst.vs", vSyncPulse, 0);
        chk("rst.ls", lineStart, 0);
        chk("rst.fs", frameStart, 0);
        chk("rst.hsN", hSyncPulseN, 1);
        chk("rst.vsN", vSyncPulseN, 1);

        // ---- first enabled edge lands on (0,0) ----
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        chk("first.DE", DE, 1);
        chk("first.xPos", xPos, 0);
        chk("first.yPos", yPos, 0);
        chk("first.fs", frameStart, 1);
        chk("first.ls", lineStart, 1);
        checkAll("first");

        // ---- two full frames ----
        deLine0 = int'(DE);
        hsLine0 = int'(hSyncPulse);
        frames  = int'(frameStart);
        vsCycles = int'(vSyncPulse);
        vsRiseH = -1;
        prevVs  = vSyncPulse;
        for (int i = 1; i < 224; i++) begin
            tick();
            checkAll("run");
            if (i < 14) begin
                deLine0 += int'(DE);
                hsLine0 += int'(hSyncPulse);
            end
            frames   += int'(frameStart);
            vsCycles += int'(vSyncPulse);
            if (vSyncPulse && !prevVs && vsRiseH < 0) vsRiseH = h;
            prevVs = vSyncPulse;
        end
        chk("line0.deCycles", deLine0, 8);
        chk("line0.hsCycles", hsLine0, 3);
        chk("frames.in224", frames, 2);
        chk("vs.cycles2frames", vsCycles, 56);
        chk("vs.riseAtH0", vsRiseH, 0);

        // ---- enable held low at hCount 7 ----
        for (int i = 0; i < 100 && h != 7; i++) begin
            tick();
            checkAll("toH7");
        end
        chk("hold.reach.xPos", xPos, 7);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold.DE", DE, 1);
            chk("hold.xPos", xPos, 7);
            chk("hold.ls", lineStart, 0);
            checkAll("hold");
        end
        enable = 1'b1;
        tick();
        chk("resume.DE", DE, 0);
        chk("resume.xPos", xPos, 0);
        checkAll("resume");

        // ---- asynchronous reset mid-frame at (5,2) ----
        for (int i = 0; i < 200 && !(h == 5 && v == 2); i++) begin
            tick();
            checkAll("toMid");
        end
        chk("mid.reach.xPos", xPos, 5);
        chk("mid.reach.yPos", yPos, 2);
        reset_n = 1'b0;
        #1;
        chk("arst.DE", DE, 0);
        chk("arst.xPos", xPos, 0);
        chk("arst.yPos", yPos, 0);
        chk("arst.hs", hSyncPulse, 0);
        chk("arst.hsN", hSyncPulseN, 1);
        chk("arst.vsN", vSyncPulseN, 1);
        h = 13;
        v = 7;
        tick();
        tick();
        checkAll("arstHeld");
        reset_n = 1'b1;
        tick();
        chk("rel.fs", frameStart, 1);
        chk("rel.DE", DE, 1);
        checkAll("rel");

`ifdef VTG_FRAME_COUNT_EN
        // ---- frame counter ----
        chk("fc.first", frameCount, 1);
        for (int f = 2; f <= 3; f++) begin
            for (int i = 0; i < 112; i++) tick();
            chk("fc.frame", frameCount, f);
        end
        force dut.frameCount = 16'hFFFF;
        #1;
        release dut.frameCount;
        for (int i = 0; i < 112; i++) tick();
        chk("fc.wrap", frameCount, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
